lfsr_seq_ctrl: RTL and testbench

- Command-driven sequencer wrapping a loadable, stallable Fibonacci LFSR datapath.
- Accepts a (seed, word count) command over valid/ready, then streams LFSR states over valid/ready with backpressure.
- Signals completion, abort and zero-seed correction.
- Sits between a test/config host and consumers of pseudo-random words (scramblers, BIST pattern sources).

---
 rtl/lfsr_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command-driven sequencer streaming Fibonacci LFSR states over valid/ready.
// Define LFSR_PERIOD_CHECK_EN to enable the seed-return (wrap) detector and period capture.
`timescale 1ns/1ps

module lfsr_seq_ctrl #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'h1D),
    parameter int unsigned      CNT_W        = 16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(8'h01)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_seed,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             seed_err,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;

    logic             r_cmd_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_seed_err;
    logic             w_seed_err_nxt;

    logic             w_accept;
    logic             w_xfer;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_seed_sel;
    logic             w_fb;
    logic [WIDTH-1:0] w_lfsr_step;

    // Handshake qualifiers and LFSR datapath
    assign w_accept    = (r_state == IDLE) && cmd_valid;
    assign w_xfer      = (r_state == RUN) && out_ready;
    assign w_seed_zero = (cmd_seed == '0);
    assign w_seed_sel  = w_seed_zero ? DEFAULT_SEED : cmd_seed;
    assign w_fb        = ^(r_lfsr & TAPS);
    assign w_lfsr_step = {w_fb, r_lfsr[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and pulse decode
    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_remaining_nxt = r_remaining;
        w_seed_err_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_lfsr_nxt      = w_seed_sel;
                    w_remaining_nxt = cmd_count;
                    w_seed_err_nxt  = w_seed_zero;
                    w_state_nxt     = (cmd_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    w_lfsr_nxt      = w_lfsr_step;
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
                // abort wins over completion: no done pulse after an abort
                if (abort) begin
                    w_state_nxt = IDLE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr      <= '0;
            r_remaining <= '0;
            r_cmd_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_seed_err  <= 1'b0;
        end else begin
            r_lfsr      <= w_lfsr_nxt;
            r_remaining <= w_remaining_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == RUN);
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
            r_seed_err  <= w_seed_err_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_lfsr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign seed_err  = r_seed_err;

`ifdef LFSR_PERIOD_CHECK_EN
    logic [WIDTH-1:0] r_seed_reg;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] r_period_len;
    logic             r_wrap;

    // Flags a return to the seed; period_len is a debug-only capture of the step count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seed_reg   <= '0;
            r_step_cnt   <= '0;
            r_period_len <= '0;
            r_wrap       <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_accept) begin
                r_seed_reg <= w_seed_sel;
                r_step_cnt <= '0;
            end else if (w_xfer) begin
                r_step_cnt <= r_step_cnt + CNT_W'(1);
                if (w_lfsr_step == r_seed_reg) begin
                    r_wrap       <= 1'b1;
                    r_period_len <= r_step_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign wrap = r_wrap;
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: randomized self-checking bench; a transaction-level model predicts
// every word, handshake level and status pulse of lfsr_seq_ctrl.
`timescale 1ns/1ps

module tb_lfsr_seq_ctrl;

    localparam logic [7:0] TAPS_M   = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_seed;
    logic [15:0] cmd_count;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic        seed_err;
    logic        wrap;

    int n_vec = 0;
    int n_err = 0;

    lfsr_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_seed  (cmd_seed),
        .cmd_count (cmd_count),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .seed_err  (seed_err),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Spec step rule in plain arithmetic: parity of tapped bits shifted in at the top
    function automatic logic [7:0] next_word(input logic [7:0] s);
        int fb;
        fb = $countones(s & TAPS_M) % 2;
        return 8'((s >> 1) | (fb << 7));
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    // One command end to end; called and returning on a falling edge with the DUT idle
    task automatic run_cmd(input logic [7:0] seed, input int count, input bit rnd,
                           input int abort_idx, input int stall_idx, input int rst_idx);
        logic [7:0] exp_q[$];
        logic [7:0] sel;
        logic [7:0] w;
        int         idx;
        int         stall_n;
        int         budget;
        bit         first;
        bit         fin;
        bit         do_abort;
        bit         exp_wrap;

        sel = (seed == 8'h00) ? DEF_SEED : seed;
        w   = sel;
        for (int i = 0; i < count; i++) begin
            exp_q.push_back(w);
            w = next_word(w);
        end

        check("accept_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_seed  = seed;
        cmd_count = 16'(count);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_seed  = 8'($urandom);
        cmd_count = 16'($urandom);

        idx      = 0;
        stall_n  = 0;
        first    = 1'b1;
        fin      = 1'b0;
        exp_wrap = 1'b0;
        budget   = count * 8 + 20;
        while (!fin && budget > 0) begin
            budget--;
            check("seed_err", 32'(seed_err), 32'(first && (seed == 8'h00)));
            check("wrap", 32'(wrap), 32'(exp_wrap));
            first    = 1'b0;
            exp_wrap = 1'b0;
            if (idx < count && idx == rst_idx) begin
                rst       = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check("rst_out_valid", 32'(out_valid), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_seed_err", 32'(seed_err), 0);
                check("rst_wrap", 32'(wrap), 0);
                rst = 1'b1;
                @(negedge clk);
                check_idle("post_rst");
                fin = 1'b1;
            end else if (idx < count) begin
                check("run_out_valid", 32'(out_valid), 1);
                check("run_out_data", 32'(out_data), 32'(exp_q[idx]));
                check("run_busy", 32'(busy), 1);
                check("run_done", 32'(done), 0);
                check("run_cmd_ready", 32'(cmd_ready), 0);
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (idx == stall_idx && stall_n < 3) begin
                    out_ready = 1'b0;
                    stall_n++;
                end
                do_abort = (idx == abort_idx);
                if (do_abort) out_ready = 1'b1;
                abort     = do_abort;
                cmd_valid = rnd && ($urandom_range(0, 1) == 1);
                if (out_ready) begin
`ifdef LFSR_PERIOD_CHECK_EN
                    exp_wrap = (next_word(exp_q[idx]) == sel);
`endif
                    idx++;
                end
                @(negedge clk);
                abort     = 1'b0;
                cmd_valid = 1'b0;
                if (do_abort) begin
                    check("abort_wrap", 32'(wrap), 32'(exp_wrap));
                    check_idle("abort");
                    fin = 1'b1;
                end
            end else begin
                check("fin_done", 32'(done), 1);
                check("fin_out_valid", 32'(out_valid), 0);
                check("fin_busy", 32'(busy), 1);
                check("fin_cmd_ready", 32'(cmd_ready), 0);
                abort     = ($urandom_range(0, 1) == 1);
                cmd_valid = rnd && ($urandom_range(0, 1) == 1);
                @(negedge clk);
                abort     = 1'b0;
                cmd_valid = 1'b0;
                check_idle("after_done");
                fin = 1'b1;
            end
        end
        out_ready = 1'b0;
        if (!fin) check("timeout", 0, 1);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_seed  = 8'h00;
        cmd_count = 16'h0000;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_seed_err", 32'(seed_err), 0);
        check("reset_wrap", 32'(wrap), 0);
        check("reset_out_data", 32'(out_data), 0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("idle");

        // abort and cmd-less cycles in IDLE must be ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("idle_abort");

        run_cmd(8'h01, 7, 1'b0, -1, -1, -1);
        run_cmd(8'h00, 2, 1'b0, -1, -1, -1);
        run_cmd(8'h01, 5, 1'b0, -1,  2, -1);
        run_cmd(8'h01, 7, 1'b0,  2, -1, -1);
        run_cmd(8'hA5, 0, 1'b0, -1, -1, -1);
        run_cmd(8'h00, 0, 1'b0, -1, -1, -1);
        run_cmd(8'h01, 7, 1'b0, -1, -1,  2);
        run_cmd(8'h3C, 1, 1'b0, -1, -1, -1);
        run_cmd(8'h01, 256, 1'b1, -1, -1, -1);

        for (int t = 0; t < 30; t++) begin
            logic [7:0] s;
            int         c;
            int         ab;
            s  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            c  = $urandom_range(0, 40);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
            run_cmd(s, c, 1'b1, ab, $urandom_range(0, 40), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
